seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential radix-2 restoring divider; the inverse of dadda_multiplier.
//  - Takes a 2*WIDTH-bit dividend (product width) and a WIDTH-bit divisor.
//  - Returns a WIDTH-bit quotient and a WIDTH-bit remainder after WIDTH iterations.
//  - Valid/ready on both sides, so it sits next to the multiplier in the arithmetic datapath.
// PARAMETERS
//  WIDTH   4   operand width: divisor, quotient and remainder are WIDTH bits; dividend is 2*WIDTH
// PORTS
//  clock        in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        dividend/divisor valid
//  in_ready     out  1        block idle, can accept
//  dividend     in   2*WIDTH  numerator, unsigned
//  divisor      in   WIDTH    denominator, unsigned
//  out_valid    out  1        result valid, held until taken
//  out_ready    in   1        consumer takes result
//  quotient     out  WIDTH    unsigned quotient
//  remainder    out  WIDTH    unsigned remainder
//  div_by_zero  out  1        divisor was 0
//  overflow     out  1        quotient does not fit in WIDTH bits
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//  - state=IDLE; in_ready=1; out_valid=0.
//  - quotient, remainder, div_by_zero, overflow all 0.
//  FSM states: IDLE, CALC, DONE.
//  - IDLE: in_ready=1. The accept edge e0 is the edge where in_valid=1. On e0, latch the operands:
//    - divisor==0 -> DONE; div_by_zero=1, overflow=0.
//    - else dividend[2W-1:W] >= divisor -> DONE; overflow=1, div_by_zero=0.
//    - error result: quotient={WIDTH{1}}, remainder=dividend[W-1:0].
//    - else -> CALC; partial remainder = dividend[2W-1:W]; iteration count=0.
//  - CALC: in_ready=0; one iteration per edge (e1..eW).
//    - Shift {rem,dividend bits} left by 1.
//    - Trial subtract divisor, using a WIDTH+1-bit compare so the carry is not lost.
//    - Quotient bit = 1 if no borrow, keeping the difference; else 0, restoring.
//    - After edge eW -> DONE.
//  - DONE: out_valid=1; all outputs stable. Edge with out_ready=1 -> IDLE, out_valid=0.
//  Latency:
//  - Normal case: out_valid is first high in the cycle after eW (W edges after accept).
//  - Error case: out_valid is first high in the cycle after e0.
//  Boundary and sequencing rules:
//  - in_ready=0 in CALC and DONE. No accept in the same cycle as an output handshake (one bubble).
//  - in_valid in CALC/DONE is ignored; operand inputs may change freely outside IDLE.
//  - out_ready in IDLE/CALC is ignored.
//  - Reset mid-CALC or mid-DONE aborts the operation immediately; there is no output pulse.
//  - Flags are mutually exclusive; both are 0 on a normal result and are cleared on the next accept.
//  - Invariant on a normal result: quotient*divisor + remainder == dividend, and remainder < divisor.
// CONFIGURATION
//  DIV_CHECK_EN defined:
//  - Adds output chk_err (1 bit, reset 0).
//  - When entering DONE via CALC, the block computes quotient*divisor+remainder combinationally
//    (2*WIDTH bits) and compares it with the latched dividend.
//  - chk_err=1 on mismatch, held with out_valid, cleared on output handshake or reset.
//  - chk_err=0 for error results.
//  DIV_CHECK_EN undefined: chk_err port and check logic absent; all other behaviour identical.
// TESTING  (WIDTH=4)
//  - 0x0F / 0x3 -> quotient=5, remainder=0, flags 0; out_valid first high 4 edges after accept.
//  - 0x1E / 0x7 -> quotient=4, remainder=2; 0x3C / 0x4 -> quotient=F, remainder=0 (max fit).
//  - 0x40 / 0x4 -> overflow=1, quotient=F, remainder=0, out_valid after 1 edge;
//    0x25 / 0x0 -> div_by_zero=1, quotient=F, remainder=5.
//  - Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored;
//    then out_ready=1 -> IDLE next edge.
//  - Assert rst_n=0 at CALC iteration 2 -> out_valid=0, in_ready=1 immediately;
//    a new op after release gives correct results.
//  - Exhaustive sweep of all 256x16 operand pairs, back-to-back with out_ready=1:
//    results match dividend/divisor and dividend%divisor (or the flags);
//    with DIV_CHECK_EN, chk_err stays 0.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, valid/ready on both sides.
// Optional self-check of each normal result is enabled by defining DIV_CHECK_EN (adds output chk_err).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
`ifdef DIV_CHECK_EN
  ,output logic              chk_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   shq_q, shq_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [WIDTH:0]     trial_s;
  logic [WIDTH+1:0]   diff_s;
  logic               borrow_s;
  logic [WIDTH-1:0]   rem_nx_s;
  logic [WIDTH-1:0]   shq_nx_s;

`ifdef DIV_CHECK_EN
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic               chk_err_q, chk_err_d;
  logic [2*WIDTH-1:0] recon_s;
  logic               chk_mis_s;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract with a spare bit for the borrow.
  always_comb begin
    trial_s  = {rem_q, shq_q[WIDTH-1]};
    diff_s   = {1'b0, trial_s} - {2'b00, dvs_q};
    borrow_s = diff_s[WIDTH+1];
    if (borrow_s) begin
      rem_nx_s = trial_s[WIDTH-1:0];
    end else begin
      rem_nx_s = diff_s[WIDTH-1:0];
    end
    shq_nx_s = {shq_q[WIDTH-2:0], ~borrow_s};
  end

`ifdef DIV_CHECK_EN
  // Rebuild the dividend from the final quotient and remainder to catch datapath faults.
  always_comb begin
    recon_s   = ({{WIDTH{1'b0}}, shq_nx_s} * {{WIDTH{1'b0}}, dvs_q}) + {{WIDTH{1'b0}}, rem_nx_s};
    chk_mis_s = (recon_s != dvd_q);
  end
`endif

  // Next-state and datapath control; the low shift register turns into the quotient as bits shift in.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    shq_d       = shq_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rmd_d       = rmd_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef DIV_CHECK_EN
    dvd_d       = dvd_q;
    chk_err_d   = chk_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvs_d      = divisor;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
`ifdef DIV_CHECK_EN
          dvd_d      = dividend;
          chk_err_d  = 1'b0;
`endif
          if (divisor == {WIDTH{1'b0}}) begin
            state_d     = S_DONE;
            dbz_d       = 1'b1;
            quo_d       = {WIDTH{1'b1}};
            rmd_d       = dividend[WIDTH-1:0];
            out_valid_d = 1'b1;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            state_d     = S_DONE;
            ovf_d       = 1'b1;
            quo_d       = {WIDTH{1'b1}};
            rmd_d       = dividend[WIDTH-1:0];
            out_valid_d = 1'b1;
          end else begin
            state_d = S_CALC;
            rem_d   = dividend[2*WIDTH-1:WIDTH];
            shq_d   = dividend[WIDTH-1:0];
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = rem_nx_s;
        shq_d = shq_nx_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = S_DONE;
          quo_d       = shq_nx_s;
          rmd_d       = rem_nx_s;
          out_valid_d = 1'b1;
`ifdef DIV_CHECK_EN
          chk_err_d   = chk_mis_s;
`endif
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef DIV_CHECK_EN
          chk_err_d   = 1'b0;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
`ifdef DIV_CHECK_EN
        chk_err_d   = 1'b0;
`endif
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= {WIDTH{1'b0}};
      shq_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      rmd_q       <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef DIV_CHECK_EN
      dvd_q       <= {(2*WIDTH){1'b0}};
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      shq_q       <= shq_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rmd_q       <= rmd_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef DIV_CHECK_EN
      dvd_q       <= dvd_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
`ifdef DIV_CHECK_EN
  assign chk_err     = chk_err_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep bench for seq_divider (WIDTH=4); outputs sampled 1 time unit after the rising edge.
module tb_seq_divider;

  logic       clock;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;
`ifdef DIV_CHECK_EN
  logic       chk_err;
`endif

  int n_cmp;
  int n_err;

  seq_divider #(.WIDTH(4)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
`ifdef DIV_CHECK_EN
    ,.chk_err    (chk_err)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for the result and check it, then take it.
  task automatic run_op(input logic [7:0] dvd, input logic [3:0] dvs,
                        input logic [3:0] exp_q, input logic [3:0] exp_r,
                        input logic exp_dbz, input logic exp_ovf,
                        input int exp_lat, input logic hold_rdy);
    int lat;
    @(negedge clock);
    check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    out_ready = hold_rdy;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    dividend = ~dvd;
    divisor  = ~dvs;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_val("latency", lat, exp_lat);
    check_val("quotient", {28'd0, quotient}, {28'd0, exp_q});
    check_val("remainder", {28'd0, remainder}, {28'd0, exp_r});
    check_val("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dbz});
    check_val("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    check_val("in_ready_busy", {31'd0, in_ready}, 32'd0);
`ifdef DIV_CHECK_EN
    check_val("chk_err", {31'd0, chk_err}, 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = hold_rdy;
    check_val("out_valid_taken", {31'd0, out_valid}, 32'd0);
    check_val("in_ready_taken", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [3:0] eq, er;
    logic       ed, eo;
    int         el;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'h00;
    divisor   = 4'h0;
    #12;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_quotient", {28'd0, quotient}, 32'd0);
    check_val("rst_remainder", {28'd0, remainder}, 32'd0);
    check_val("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    // directed vectors
    run_op(8'h0F, 4'h3, 4'h5, 4'h0, 1'b0, 1'b0, 4, 1'b0);
    run_op(8'h1E, 4'h7, 4'h4, 4'h2, 1'b0, 1'b0, 4, 1'b0);
    run_op(8'h3C, 4'h4, 4'hF, 4'h0, 1'b0, 1'b0, 4, 1'b0);
    run_op(8'h40, 4'h4, 4'hF, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'h25, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'hFF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'hEF, 4'hF, 4'hF, 4'hE, 1'b0, 1'b0, 4, 1'b0);

    // hold the result for three cycles while in_valid pulses with other operands
    @(negedge clock);
    in_valid = 1'b1;
    dividend = 8'h1E;
    divisor  = 4'h7;
    @(posedge clock);
    #1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_val("hold_latency", lat, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      dividend = 8'h0F;
      divisor  = 4'h3;
      @(posedge clock);
      #1;
      check_val("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check_val("hold_quotient", {28'd0, quotient}, 32'd4);
      check_val("hold_remainder", {28'd0, remainder}, 32'd2);
      check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_val("hold_release_valid", {31'd0, out_valid}, 32'd0);
    check_val("hold_release_ready", {31'd0, in_ready}, 32'd1);

    // reset during the second iteration
    @(negedge clock);
    in_valid = 1'b1;
    dividend = 8'h3C;
    divisor  = 4'h7;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check_val("calc_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check_val("abort_no_pulse", {31'd0, out_valid}, 32'd0);
    run_op(8'h3C, 4'h7, 4'h8, 4'h4, 1'b0, 1'b0, 4, 1'b0);

    // exhaustive sweep with out_ready held high
    out_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'hF; er = a[3:0]; ed = 1'b1; eo = 1'b0; el = 0;
        end else if (a / b > 15) begin
          eq = 4'hF; er = a[3:0]; ed = 1'b0; eo = 1'b1; el = 0;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); ed = 1'b0; eo = 1'b0; el = 4;
        end
        run_op(8'(a), 4'(b), eq, er, ed, eo, el, 1'b1);
      end
    end
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
